// File: rtl/mmio_console.sv
// Memory-mapped console peripheral.
// The CPU stores bytes into a TX FIFO, and the FIFO drains them to a
// valid/ready byte sink. The peripheral also exposes a STATUS register
// and a free-running CYCLE counter inside a 16-byte register window.
module mmio_console #(
    parameter logic [31:0] BASE_ADDR = 32'hF000_0000,
    parameter int          DEPTH     = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] memory_address,
    input  logic [31:0] memory_write,
    input  logic [3:0]  memory_byte_enable,
    input  logic        memory_we,
    output logic [31:0] memory_read,
    output logic        selected,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        overflow
);

    localparam int        AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    localparam logic [1:0] OFF_TXDATA = 2'd0;
    localparam logic [1:0] OFF_STATUS = 2'd1;
    localparam logic [1:0] OFF_CYCLE  = 2'd2;

    logic [7:0]  mem [DEPTH];
    logic [AW:0] wptr;
    logic [AW:0] rptr;
    logic [AW:0] count;
    logic [7:0]  count_byte;
    logic [31:0] cycle;
    logic [1:0]  offset;
    logic        full;
    logic        empty;
    logic        push_req;
    logic        push_ok;
    logic        pop;
    logic        drop;
    logic        ovf_clear;
    logic [31:0] status_word;
    logic        unused_bits;

    // Address decode. The low two address bits select nothing.
    assign selected = (memory_address[31:4] == BASE_ADDR[31:4]);
    assign offset   = memory_address[3:2];

    // Pointer-derived FIFO state. The extra MSB tells full from empty.
    assign full       = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign empty      = (wptr == rptr);
    assign count      = wptr - rptr;
    assign count_byte = 8'(count);

    // Store and drain handshakes. A pop in the same cycle frees the slot
    // that a push into a full FIFO needs, so that push still succeeds.
    assign push_req  = memory_we && selected && (offset == OFF_TXDATA) && memory_byte_enable[0];
    assign pop       = tx_valid && tx_ready;
    assign push_ok   = push_req && (!full || pop);
    assign drop      = push_req && full && !pop;
    assign ovf_clear = memory_we && selected && (offset == OFF_STATUS)
                       && memory_byte_enable[0] && memory_write[2];

    assign tx_valid    = !empty;
    assign status_word = {16'h0000, count_byte, 5'b00000, overflow, empty, full};

    // Bits that the register map never looks at.
    assign unused_bits = ^{memory_address[1:0], memory_write[31:8], memory_byte_enable[3:1]};

    // Head byte. An empty FIFO shows 0 so stale contents never leak out.
    always_comb begin
        tx_data = 8'h00;
        if (!empty) begin
            tx_data = mem[rptr[AW-1:0]];
        end else begin
            tx_data = 8'h00;
        end
    end

    // Zero-latency register read mux, driven by registered state only.
    always_comb begin
        memory_read = 32'h0000_0000;
        if (selected) begin
            case (offset)
                OFF_STATUS: memory_read = status_word;
                OFF_CYCLE:  memory_read = cycle;
                default:    memory_read = 32'h0000_0000;
            endcase
        end else begin
            memory_read = 32'h0000_0000;
        end
    end

    // FIFO storage. Contents need no reset because the pointers gate them.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wptr[AW-1:0]] <= memory_write[7:0];
        end
    end

    // Write and read pointers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push_ok) begin
                wptr <= wptr + PTR_ONE;
            end
            if (pop) begin
                rptr <= rptr + PTR_ONE;
            end
        end
    end

    // Sticky overflow flag. A drop in the same cycle as a clear wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (ovf_clear) begin
            overflow <= 1'b0;
        end
    end

    // Free-running cycle counter, wraps naturally at 32 bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle <= 32'h0000_0000;
        end else begin
            cycle <= cycle + 32'h0000_0001;
        end
    end

endmodule

// File: doc/mmio_console.md
Name: mmio_console

Overview:
- Memory-mapped console peripheral. It is the responder on the CPU data-memory interface (address, write data, byte enable, write enable, read data).
- It decodes a small register window, buffers bytes the CPU stores into a TX FIFO, and drains them to a byte sink over a valid/ready stream.
- It sits beside ram in CPU program benches. The bench muxes read data using `selected`.

Parameters:
- BASE_ADDR, 32'hF000_0000, base of the 16-byte register window; must be 16-byte aligned.
- DEPTH, 8, TX FIFO entries; power of two, 2..256.

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous active-high reset
- memory_address  input  32  CPU data address
- memory_write  input  32  CPU store data
- memory_byte_enable  input  4  store byte lanes
- memory_we  input  1  store strobe
- memory_read  output  32  read data (combinational)
- selected  output  1  address is inside the window
- tx_data  output  8  FIFO head byte
- tx_valid  output  1  FIFO non-empty
- tx_ready  input  1  sink accepts byte
- overflow  output  1  sticky dropped-byte flag

Behaviour:
- Decode: `selected` = (memory_address[31:4] == BASE_ADDR[31:4]), combinational. Register offset = memory_address[3:2]; bits [1:0] are ignored.
- Registers:
  - 0x0 TXDATA: write-only; reads return 0.
  - 0x4 STATUS: read = {16'b0, count[7:0], 5'b0, overflow, empty, full}. count is zero-extended to 8 bits.
  - 0x8 CYCLE: free-running 32-bit counter, read-only; writes are ignored.
  - 0xC: reserved; reads 0, writes ignored.
- Reads: memory_read is combinational from current registered state, with zero latency, matching single-cycle CPU loads. memory_read = 0 when not selected.
- Push: memory_we & selected & offset 0 & memory_byte_enable[0]. memory_write[7:0] is enqueued at the rising edge. Other lanes are ignored. A store with be[0]=0 does nothing.
- Pop: tx_valid & tx_ready at the rising edge; the head advances.
- tx_valid = !empty. tx_data = head entry. tx_data is held stable while tx_valid & !tx_ready.
- Full and simultaneous pop: a push is accepted when !full OR a pop occurs in the same cycle. Count is unchanged on simultaneous push and pop.
- Full, no pop: the pushed byte is dropped, FIFO contents are unchanged, and overflow is set the next cycle.
- Overflow clear: a store to STATUS with be[0]=1 and memory_write[2]=1 clears overflow (W1C). If a drop and a clear occur in the same cycle, set wins.
- Empty and push: a simultaneous push on an empty FIFO cannot pop, because tx_valid is 0. tx_valid rises the cycle after the push.
- Pointers: read/write pointers are log2(DEPTH)+1 bits and wrap modulo 2*DEPTH.
  - full = MSBs differ and the rest are equal.
  - empty = pointers are equal.
  - count = wptr - rptr.
- CYCLE: increments every clock and wraps 32'hFFFF_FFFF -> 0.
- Reset (async, any time including mid-drain):
  - pointers, count, overflow and CYCLE go to 0; FIFO contents are discarded;
  - tx_valid=0, tx_data=0 (the head of an empty FIFO reads as 0 after reset), overflow=0, memory_read=0 unless a selected read targets STATUS, which then returns 32'h0000_0002 (empty).
- Stores outside the window have no effect; ram handles them.

Test Plan:
- Reset, then read BASE+4 -> memory_read=32'h0000_0002. Read BASE+8 on two consecutive cycles -> values differ by 1.
- tx_ready=0; store 0x41, 0x42, 0x43 to BASE+0 -> STATUS=32'h0000_0300, tx_valid=1, tx_data=0x41. Raise tx_ready -> sink sees 0x41, 0x42, 0x43 in order, then tx_valid=0.
- tx_ready=0; store DEPTH+1 bytes (0..8) -> full=1, count=8, overflow=1. Drain yields 0..7; byte 8 is absent.
- FIFO full; store 0x55 in the same cycle as a pop -> count stays 8, overflow stays 0, 0x55 is drained last.
- overflow=1; store 32'h4 with be=4'b0001 to BASE+4 -> overflow=0. The same store with be=4'b0010 leaves overflow=1. Store 0x99 with be=4'b0010 to BASE+0 -> no push.
- Assert rst mid-drain with 5 bytes queued -> tx_valid=0 immediately. After release, STATUS=32'h0000_0002 and CYCLE restarts from 0. Read of ram address 0x100 -> selected=0, memory_read=0.
